pipelined_add_sub: RTL and testbench
====================================

// Module: pipelined_add_sub
//
// PURPOSE
// - Parametrised, pipelined WIDTH-bit adder/subtractor built from STAGES = WIDTH/CHUNK ripple chunks.
// - One register stage sits between chunks, so a new operation can be accepted every cycle.
// - Valid/ready handshake on both sides; full backpressure support.
// - Adds subtract mode, external carry-in and status flags (carry, signed overflow, zero).
// - Used by the APU datapath wherever a 32-bit or wider add must meet timing.
//
// PARAMETERS
// - WIDTH  32  operand/result width in bits; must be a multiple of CHUNK.
// - CHUNK   8  bits per pipeline stage; STAGES = WIDTH/CHUNK, must be >= 1.
//
// PORTS
// - clk        in   1      single clock; all state updates on rising edge.
// - reset      in   1      synchronous, active-high reset.
// - inValid    in   1      a/b/carryIn/subtract are valid this cycle.
// - inReady    out  1      block accepts the operation this cycle.
// - a          in   WIDTH  operand A.
// - b          in   WIDTH  operand B.
// - carryIn    in   1      carry into bit 0.
// - subtract   in   1      0: a+b+carryIn; 1: a+~b+carryIn (carryIn=1 gives a-b).
// - outValid   out  1      result fields are valid.
// - outReady   in   1      consumer accepts the result this cycle.
// - sum        out  WIDTH  result, mod 2^WIDTH.
// - carryOut   out  1      carry out of bit WIDTH-1 (raw, not inverted for subtract).
// - overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB.
// - zero       out  1      sum == 0.
//
// BEHAVIOUR
// - Global advance enable: adv = !outValid || outReady. inReady = adv; the pipeline moves only when adv=1.
// - Transfer in: inValid && inReady. Transfer out: outValid && outReady.
// - Stage k (0..STAGES-1) adds chunk k of a and b' (b' = subtract ? ~b : b).
//   - Stage 0 carry-in is carryIn; stage k>0 uses the carry registered from stage k-1.
//   - Upper operand chunks travel in skew registers.
//   - Completed lower sum chunks travel in deskew registers.
// - Latency: exactly STAGES cycles from input transfer to outValid, with no stalls.
//   - Each stall cycle (adv=0) adds one cycle; no data is lost or duplicated.
// - Each stage holds a valid bit, shifted on adv.
//   - A bubble (inValid=0 at adv) inserts valid=0.
//   - Stalled contents and outputs hold steady while outValid && !outReady.
// - Result fields are registered with the last stage and change only on adv.
//   - Flags derive from that same operation: overflow = c[WIDTH-1] ^ c[WIDTH]; zero computed on the full sum.
// - Throughput: 1 op/cycle while outReady=1; back-to-back ops must not interfere.
// - Reset, cycle after reset asserted:
//   - All valid bits = 0; outValid = 0.
//   - sum, carryOut, overflow, zero = 0.
//   - inReady = 1 once reset deasserts (inReady is don't-care while reset=1; inputs are ignored).
// - Reset mid-operation discards all in-flight ops; no partial result is emitted.
// - Width rules:
//   - Chunk adds are CHUNK+1 bits wide; the MSB is the carry.
//   - No sign extension; operands are two's complement for overflow purposes only.
// - STAGES=1 degenerates to a single registered adder with latency 1.
//
// STRUCTURE
// - Shared package apu_arith_pkg:
//   - Localparam helpers STAGES = WIDTH/CHUNK.
//   - Flag bit positions for the status bundle (CARRY=0, OVF=1, ZERO=2), reused by other APU arithmetic units.
// - Sub-module adder_stage:
//   - CHUNK-bit ripple add with registered sum chunk, carry and valid.
//   - Generated STAGES times; skew/deskew registers stay in the top.
// - Elaboration check: WIDTH % CHUNK != 0 is a fatal error.
//
// TESTING
// - Reset then single add: a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> after 4 cycles sum=0x0000_0100, carryOut=0, ovf=0, zero=0.
// - Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0001 -> sum=0, carryOut=1, zero=1, ovf=0.
// - Signed overflow and subtract:
//   - a=0x7FFF_FFFF + b=1 -> sum=0x8000_0000, ovf=1.
//   - sub=1, cin=1, a=5, b=7 -> sum=0xFFFF_FFFE, carryOut=0, ovf=0.
// - Streaming with backpressure: 16 back-to-back random ops, outReady toggled pseudo-randomly -> results match the model, in order, none dropped or duplicated; outputs stable during stalls.
// - Reset mid-flight: issue 3 ops, assert reset on cycle 2 -> outValid stays 0; the first op after reset returns the correct result at latency 4.
// - Parameter sweep WIDTH/CHUNK = 32/8, 64/16, 16/16, 8/1 -> random self-checking results against a+b'+cin.

Source files
------------

// File: rtl/apu_arith_pkg.sv
// Shared definitions for the APU arithmetic units: status flag layout and
// pipeline sizing helper.
package apu_arith_pkg;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_W     = 3;

  typedef logic [FLAG_W-1:0] flags_t;

  // Number of ripple chunks (and pipeline stages) for a given datapath width.
  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit ripple add slice with registered sum, valid and status flags.
// The zero flag accumulates across slices; overflow is only meaningful on the top slice.
module adder_stage
  import apu_arith_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             valid_in,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  input  logic             zero_in,
  output logic             valid,
  output logic [CHUNK-1:0] sum,
  output flags_t           flags
);

  localparam int unsigned CW = CHUNK + 1;

  logic [CHUNK:0] full_c;
  logic           msb_carry_c;

  // Carry into the slice MSB is recovered from the MSB sum bit.
  always_comb begin
    full_c      = {1'b0, a} + {1'b0, b} + CW'(carry_in);
    msb_carry_c = a[CHUNK-1] ^ b[CHUNK-1] ^ full_c[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      sum   <= '0;
      flags <= '0;
    end else if (adv) begin
      valid             <= valid_in;
      sum               <= full_c[CHUNK-1:0];
      flags[FLAG_CARRY] <= full_c[CHUNK];
      flags[FLAG_OVF]   <= msb_carry_c ^ full_c[CHUNK];
      flags[FLAG_ZERO]  <= zero_in && (full_c[CHUNK-1:0] == '0);
    end
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple slices separated by
// registers, valid/ready on both sides, one global advance enable.
module pipelined_add_sub
  import apu_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  input  logic             subtract,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);

  if (CHUNK == 0) begin : g_bad_chunk
    $fatal(1, "pipelined_add_sub: CHUNK must be non-zero");
  end else if (((WIDTH % CHUNK) != 0) || (STAGES < 1)) begin : g_bad_width
    $fatal(1, "pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv_c;
  logic [WIDTH-1:0] b_eff_c;

  // The whole pipeline moves together; a held result stalls every stage.
  assign adv_c   = !outValid || outReady;
  assign inReady = adv_c;
  assign b_eff_c = subtract ? ~b : b;

  logic [CHUNK-1:0] st_a     [STAGES];
  logic [CHUNK-1:0] st_b     [STAGES];
  logic             st_cin   [STAGES];
  logic             st_zin   [STAGES];
  logic             st_vin   [STAGES];
  logic             st_valid [STAGES];
  logic [CHUNK-1:0] st_sum   [STAGES];
  flags_t           st_flags [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign st_a[s]   = a[CHUNK-1:0];
      assign st_b[s]   = b_eff_c[CHUNK-1:0];
      assign st_cin[s] = carryIn;
      assign st_zin[s] = 1'b1;
      assign st_vin[s] = inValid;
    end else begin : g_body
      assign st_a[s]   = g_skw[s].qa[CHUNK-1:0];
      assign st_b[s]   = g_skw[s].qb[CHUNK-1:0];
      assign st_cin[s] = st_flags[s-1][FLAG_CARRY];
      assign st_zin[s] = st_flags[s-1][FLAG_ZERO];
      assign st_vin[s] = st_valid[s-1];
    end

    adder_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .adv      (adv_c),
      .valid_in (st_vin[s]),
      .a        (st_a[s]),
      .b        (st_b[s]),
      .carry_in (st_cin[s]),
      .zero_in  (st_zin[s]),
      .valid    (st_valid[s]),
      .sum      (st_sum[s]),
      .flags    (st_flags[s])
    );
  end

  // Skew: g_skw[s] holds operand chunks s..STAGES-1, aligned with stage s-1 output.
  for (genvar s = 1; s < STAGES; s++) begin : g_skw
    logic [(STAGES-s)*CHUNK-1:0] qa;
    logic [(STAGES-s)*CHUNK-1:0] qb;
    logic [(STAGES-s)*CHUNK-1:0] qa_src_c;
    logic [(STAGES-s)*CHUNK-1:0] qb_src_c;

    if (s == 1) begin : g_src
      assign qa_src_c = a[WIDTH-1:CHUNK];
      assign qb_src_c = b_eff_c[WIDTH-1:CHUNK];
    end else begin : g_src
      assign qa_src_c = g_skw[s-1].qa[(STAGES-s+1)*CHUNK-1:CHUNK];
      assign qb_src_c = g_skw[s-1].qb[(STAGES-s+1)*CHUNK-1:CHUNK];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        qa <= '0;
        qb <= '0;
      end else if (adv_c) begin
        qa <= qa_src_c;
        qb <= qb_src_c;
      end
    end
  end

  // Deskew: g_dsk[s] holds finished sum chunks 0..s-1, aligned with stage s output.
  for (genvar s = 1; s < STAGES; s++) begin : g_dsk
    logic [s*CHUNK-1:0] q;
    logic [s*CHUNK-1:0] src_c;

    if (s == 1) begin : g_src
      assign src_c = st_sum[0];
    end else begin : g_src
      assign src_c = {st_sum[s-1], g_dsk[s-1].q};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        q <= '0;
      end else if (adv_c) begin
        q <= src_c;
      end
    end
  end

  assign outValid = st_valid[STAGES-1];
  assign carryOut = st_flags[STAGES-1][FLAG_CARRY];
  assign overflow = st_flags[STAGES-1][FLAG_OVF];
  assign zero     = st_flags[STAGES-1][FLAG_ZERO];

  if (STAGES == 1) begin : g_sum
    assign sum = st_sum[0];
  end else begin : g_sum
    assign sum = {st_sum[STAGES-1], g_dsk[STAGES-1].q};
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: directed corner cases, reset
// mid-flight, randomized streaming with backpressure and a parameter sweep.
module tb_pipelined_add_sub;

  localparam int unsigned W = 32;
  localparam int unsigned C = 8;
  localparam int unsigned S = W / C;
  localparam int unsigned SWEEP_OPS  = 60;
  localparam int unsigned STREAM_OPS = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryIn;
  logic         subtract;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] sum;
  logic         carryOut;
  logic         overflow;
  logic         zero;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipelined_add_sub #(
    .WIDTH (W),
    .CHUNK (C)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .a        (a),
    .b        (b),
    .carryIn  (carryIn),
    .subtract (subtract),
    .outValid (outValid),
    .outReady (outReady),
    .sum      (sum),
    .carryOut (carryOut),
    .overflow (overflow),
    .zero     (zero)
  );

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] expd);
    n_vec++;
    if (got !== expd) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, expd);
    end
  endtask

  // Reference: plain w-bit arithmetic, overflow from the two's-complement sign rule.
  function automatic logic [66:0] model(input int unsigned w, input logic [63:0] x,
                                        input logic [63:0] y, input logic cin, input logic sub);
    logic [63:0] mask;
    logic [63:0] xm;
    logic [63:0] ym;
    logic [64:0] tot;
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    ym   = (sub ? ~y : y) & mask;
    tot  = {1'b0, xm} + {1'b0, ym} + 65'(cin);
    s    = tot[63:0] & mask;
    cout = tot[w];
    ovf  = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {s, cout, ovf, (s == 64'd0)};
  endfunction

  function automatic logic [66:0] obs();
    return {64'(sum), carryOut, overflow, zero};
  endfunction

  logic [66:0] exp_q[$];
  bit          sb_en = 1'b0;
  bit          held = 1'b0;
  logic [66:0] held_val;
  int unsigned n_pop = 0;

  // Scoreboard and stall-stability monitor for the main instance.
  always @(negedge clk) begin
    if (sb_en && !reset) begin
      if (held) check_eq("hold", {obs(), outValid}, {held_val, 1'b1});
      held     = outValid && !outReady;
      held_val = obs();
      if (outValid && outReady) begin
        check_eq("sb_nonempty", 72'(exp_q.size() != 0), 72'd1);
        if (exp_q.size() != 0) check_eq("stream", obs(), exp_q.pop_front());
        n_pop++;
      end
    end
  end

  task automatic run_directed(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                              input logic cin, input logic sub, input logic [66:0] expd);
    int unsigned lat;
    @(posedge clk); #1;
    a = xa; b = xb; carryIn = cin; subtract = sub; inValid = 1'b1; outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 72'(lat), 72'(S));
    check_eq(tag, obs(), expd);
  endtask

  // Parameter sweep: independent instances, each with its own model queue.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned SW = (g == 0) ? 64 : (g == 1) ? 16 : 8;
    localparam int unsigned SC = (g == 0) ? 16 : (g == 1) ? 16 : 1;

    logic          sr, iv, ir, ci, sb, ov, ordy, co, of, zr;
    logic [SW-1:0] xa, xb, sm;
    logic [66:0]   q[$];
    int unsigned   np = 0;
    bit            done = 1'b0;

    pipelined_add_sub #(
      .WIDTH (SW),
      .CHUNK (SC)
    ) u_sw (
      .clk      (clk),
      .reset    (sr),
      .inValid  (iv),
      .inReady  (ir),
      .a        (xa),
      .b        (xb),
      .carryIn  (ci),
      .subtract (sb),
      .outValid (ov),
      .outReady (ordy),
      .sum      (sm),
      .carryOut (co),
      .overflow (of),
      .zero     (zr)
    );

    always @(negedge clk) begin
      if (!sr && ov && ordy) begin
        check_eq("sweep_nonempty", 72'(q.size() != 0), 72'd1);
        if (q.size() != 0) check_eq($sformatf("sweep%0d", g), {64'(sm), co, of, zr}, q.pop_front());
        np++;
      end
    end

    initial begin : drv
      int unsigned issued;
      int unsigned t;
      bit          pending;
      sr = 1'b1; iv = 1'b0; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0; ordy = 1'b1;
      issued = 0; pending = 1'b0;
      repeat (3) @(posedge clk);
      #1 sr = 1'b0;
      while (issued < SWEEP_OPS) begin
        @(posedge clk); #1;
        ordy = ($urandom_range(0, 3) != 0);
        if (!pending) begin
          if ($urandom_range(0, 4) != 0) begin
            xa = ($urandom_range(0, 7) == 0) ? '1 : SW'({$urandom(), $urandom()});
            xb = ($urandom_range(0, 7) == 0) ? '0 : SW'({$urandom(), $urandom()});
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            iv = 1'b1;
            pending = 1'b1;
          end else begin
            iv = 1'b0;
          end
        end
        @(negedge clk);
        if (iv && ir) begin
          q.push_back(model(SW, 64'(xa), 64'(xb), ci, sb));
          issued++;
          pending = 1'b0;
        end
      end
      @(posedge clk); #1;
      iv = 1'b0; ordy = 1'b1;
      t = 0;
      while (np < SWEEP_OPS && t < 100) begin
        @(posedge clk);
        t++;
      end
      @(negedge clk);
      check_eq($sformatf("sweep%0d_count", g), 72'(np), 72'(SWEEP_OPS));
      done = 1'b1;
    end
  end

  initial begin : main
    int unsigned issued;
    int unsigned t;
    bit          pending;
    bit          any_v;

    reset = 1'b1; inValid = 1'b0; a = '0; b = '0; carryIn = 1'b0; subtract = 1'b0;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 72'(outValid), 72'd0);
    check_eq("rst_result", obs(), 67'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_inready", 72'(inReady), 72'd1);

    run_directed("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {64'h100, 1'b0, 1'b0, 1'b0});
    run_directed("ripple",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {64'h0, 1'b1, 1'b0, 1'b1});
    run_directed("ovf_pos",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {64'h8000_0000, 1'b0, 1'b1, 1'b0});
    run_directed("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    run_directed("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    run_directed("sub_equal",  32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1, {64'h0, 1'b1, 1'b0, 1'b1});

    // Reset lands while two ops are in flight and a third is being offered.
    @(posedge clk); #1;
    a = 32'h1111_1111; b = 32'h2222_2222; inValid = 1'b1;
    @(posedge clk); #1;
    a = 32'h3333_3333; b = 32'h4444_4444;
    @(posedge clk); #1;
    a = 32'h5555_5555; b = 32'h6666_6666; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; inValid = 1'b0;
    check_eq("flight_rst_result", {obs(), outValid}, 68'd0);
    any_v = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      any_v |= outValid;
    end
    check_eq("flight_quiet", 72'(any_v), 72'd0);
    run_directed("after_rst", 32'h1357_9BDF, 32'h0246_8ACE, 1'b0, 1'b0, {64'h159E_26AD, 1'b0, 1'b0, 1'b0});

    // Randomized stream with bubbles and pseudo-random backpressure.
    @(posedge clk); #1;
    sb_en = 1'b1;
    issued = 0; pending = 1'b0;
    while (issued < STREAM_OPS) begin
      @(posedge clk); #1;
      outReady = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        if ($urandom_range(0, 4) != 0) begin
          a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom();
          b = ($urandom_range(0, 9) == 0) ? a : $urandom();
          carryIn = 1'($urandom_range(0, 1));
          subtract = 1'($urandom_range(0, 1));
          inValid = 1'b1;
          pending = 1'b1;
        end else begin
          inValid = 1'b0;
        end
      end
      @(negedge clk);
      if (inValid && inReady) begin
        exp_q.push_back(model(W, 64'(a), 64'(b), carryIn, subtract));
        issued++;
        pending = 1'b0;
      end
    end
    @(posedge clk); #1;
    inValid = 1'b0; outReady = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check_eq("stream_drain", 72'(exp_q.size()), 72'd0);
    check_eq("stream_count", 72'(n_pop), 72'(STREAM_OPS));
    sb_en = 1'b0;

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check_eq("sweep_done", 72'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 72'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
